param_write_scheduler: RTL

PARAM_WRITE_SCHEDULER -- requirements
Module: param_write_scheduler

---
 rtl/tone_gen_pkg.sv | 17 +
 rtl/param_write_scheduler_write_fifo.sv | 34 +++
 rtl/param_write_scheduler.sv | 72 +++++++
 3 files changed

// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: address map, window timing and write-request type shared by the tone generator.
package tone_gen_pkg;
  localparam logic [5:0] INCR_BASE = 6'h00;
  localparam logic [5:0] VOLUME_ADDR = 6'h04;
  localparam logic [5:0] WAVE_ADDR = 6'h08;
  localparam logic [5:0] LUT_BASE = 6'h20;
  localparam int WINDOW_LEN = 16;
  localparam int COUNT_W = 10;
  typedef struct packed {
    logic [5:0] addr;
    logic [15:0] data;
  } wr_req_t;
  // 0x0C..0x1F has no register behind it
  function automatic logic unmapped(input logic [5:0] a);
    return a >= (WAVE_ADDR + 6'd4) && a < LUT_BASE;
  endfunction
endpackage

// File: rtl/param_write_scheduler_write_fifo.sv
// write_fifo: synchronous FIFO of write requests; push refused while full even if popping.
module write_fifo
  import tone_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_in,
  input  logic    reset_in,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t wdata,
  output wr_req_t rdata,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  wr_req_t mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/param_write_scheduler.sv
// param_write_scheduler: arbitrates host/sequencer register writes around the synthesis window.
// FIXED_PRIO_EN: host always wins instead of round-robin.
module param_write_scheduler
  import tone_gen_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               host_valid_in,
  input  logic [5:0]         host_addr_in,
  input  logic [15:0]        host_data_in,
  output logic               host_ready_out,
  input  logic               seq_valid_in,
  input  logic [5:0]         seq_addr_in,
  input  logic [15:0]        seq_data_in,
  output logic               seq_ready_out,
  output logic [COUNT_W-1:0] master_count_out,
  output logic [5:0]         addr_out,
  output logic [15:0]        data_out,
  output logic               data_valid_out,
  output logic               busy_out
);
  wr_req_t host_head, seq_head, head;
  logic host_full, host_empty, seq_full, seq_empty;
  logic can_pop, pop_any, pick_seq, issue;
  write_fifo #(.DEPTH(FIFO_DEPTH)) u_host (
    .clk_in(clk_in), .reset_in(reset_in), .push(host_valid_in), .pop(pop_any && !pick_seq),
    .wdata('{addr: host_addr_in, data: host_data_in}), .rdata(host_head),
    .full(host_full), .empty(host_empty)
  );
  write_fifo #(.DEPTH(FIFO_DEPTH)) u_seq (
    .clk_in(clk_in), .reset_in(reset_in), .push(seq_valid_in), .pop(pop_any && pick_seq),
    .wdata('{addr: seq_addr_in, data: seq_data_in}), .rdata(seq_head),
    .full(seq_full), .empty(seq_empty)
  );
  assign host_ready_out = !host_full;
  assign seq_ready_out = !seq_full;
  // a pop issues next cycle, so the count that follows must be outside the window
  assign can_pop = !(master_count_out == '1 || master_count_out < COUNT_W'(WINDOW_LEN - 1));
  assign pop_any = can_pop && !(host_empty && seq_empty);
`ifdef FIXED_PRIO_EN
  assign pick_seq = !seq_empty && host_empty;
`else
  logic rr_seq;
  assign pick_seq = !seq_empty && (host_empty || rr_seq);
`endif
  assign head = pick_seq ? seq_head : host_head;
  assign issue = pop_any && !unmapped(head.addr);
  assign busy_out = !host_empty || !seq_empty || data_valid_out;
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      master_count_out <= '0;
      data_valid_out <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
`ifndef FIXED_PRIO_EN
      rr_seq <= 1'b0;
`endif
    end else begin
      master_count_out <= master_count_out + 1'b1;
      data_valid_out <= issue;
      if (issue) begin
        addr_out <= head.addr;
        data_out <= head.data;
      end
`ifndef FIXED_PRIO_EN
      if (pop_any) rr_seq <= !pick_seq;
`endif
    end
  end
endmodule
